alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one integer ALU execution stage between two requesters: port 0 is the main pipeline execute stage, port 1 is the auxiliary integer path (FPU-side integer ops / address generation).
- Takes pre-decoded control (ALU op code, neg, BranchControl, operands, tag) from each requester and arbitrates one operation per cycle.
- Executes the granted operation and returns it through a single registered result port with valid/ready back-pressure.
- Port 0 has priority. A starvation counter guarantees port 1 progress.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, width of the opaque requester tag (destination register id), returned unchanged.
- STARVE_LIMIT, 4, consecutive cycles port 1 may wait while valid before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- reqN_valid  in  1  requester N (N = 0, 1) has an operation.
- reqN_ready  out  1  operation of requester N accepted this cycle.
- reqN_ctrl  in  4  ALU op code (package encoding).
- reqN_neg  in  1  invert compare outcome.
- reqN_bc  in  2  compare kind: 01 eq, 10 signed lt, 11 unsigned lt.
- reqN_a  in  XLEN  operand A.
- reqN_b  in  XLEN  operand B / immediate.
- reqN_tag  in  TAG_W  requester tag.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts the result.
- res_id  out  1  requester that issued the result.
- res_tag  out  TAG_W  tag of the issuing requester.
- res_data  out  XLEN  ALU result.
- res_flag  out  1  compare outcome (after neg). 0 for non-compare ops.

Behaviour:
- Reset (rstn low, asynchronous): res_valid=0, res_id=0, res_tag=0, res_data=0, res_flag=0, starve_cnt=0. Reset mid-operation discards the held result; no replay.
- Stage open: adv = ~res_valid | res_ready.
- Grant selection (combinational):
  - g1 = req1_valid & (~req0_valid | starve_cnt >= STARVE_LIMIT).
  - g0 = req0_valid & ~g1.
- Ready: reqN_ready = gN & adv. Ready depends on valid; requesters must not make valid depend on ready.
- Accept: when reqN_valid & reqN_ready, the result is registered at the next clk edge. Latency is exactly 1 cycle from accept to res_valid. The result register holds all fields stable while res_valid & ~res_ready.
- res_valid next value:
  - 1 if any accept this cycle.
  - else 0 if res_ready.
  - else hold.
  - Simultaneous drain and accept gives back-to-back results with no bubble.
- starve_cnt:
  - Clears to 0 when port 1 is accepted, or when req1_valid=0.
  - Otherwise increments, saturating at STARVE_LIMIT. It increments even while adv=0.
  - With both ports continuously valid and res_ready=1, the accept pattern is STARVE_LIMIT port-0 ops followed by 1 port-1 op, repeating.
- Execution sub-module, XLEN arithmetic, modulo 2^XLEN:
  - ADD: a+b.
  - SUB: a-b.
  - LUI: b (pass operand B).
  - SLL: a<<b[4:0].
  - SRL: logical right shift by b[4:0].
  - SRA: arithmetic right shift by b[4:0].
  - AND: a&b. OR: a|b. XOR: a^b.
  - SCOMP:
    - cmp = (bc==01 ? a==b : bc==10 ? $signed(a)<$signed(b) : bc==11 ? a<b : 0).
    - flag = cmp ^ neg.
    - data = {XLEN-1 zeros, flag}.
  - Any unlisted code: data=0, flag=0.
- res_flag = 0 for every non-SCOMP op, regardless of neg.
- Requester inputs are sampled only on accept. Inputs that change while not accepted have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - The 4-bit ALU op constants: ADD=0000, SUB=0001, SCOMP=1000, LUI=1001, SLL=1010, SRL=1011, SRA=1100, AND=1101, OR=1110, XOR=1111.
  - BranchControl constants: BC_NONE=00, BC_EQ=01, BC_LT=10, BC_LTU=11.
  - A packed struct alu_req_t {ctrl, neg, bc, a, b, tag}.
- One combinational sub-module alu_exec (ctrl, neg, bc, a, b -> data, flag).
- Arbitration, starvation counter and result register stay in alu_share_arb.

Test Plan:
- Reset: hold rstn=0 with both requesters valid -> all outputs 0, reqN_ready=0. Release rstn; next cycle req0_ready=1.
- Port 0 alone, res_ready=1: SUB a=5, b=7 -> 1 cycle later res_valid=1, res_id=0, res_data=32'hFFFFFFFE, res_flag=0, tag echoed.
- Port 1 alone:
  - SCOMP bc=10, neg=1, a=32'hFFFFFFFF, b=1 -> res_flag=0, res_data=0.
  - Then SRA a=32'h80000000, b=31 -> res_data=32'hFFFFFFFF.
- Both ports valid continuously, STARVE_LIMIT=4, res_ready=1 -> res_id sequence 0,0,0,0,1,0,0,0,0,1. No result lost, tags in acceptance order.
- Back-pressure:
  - res_ready=0 with result held -> req0_ready=req1_ready=0; res_* stable for 3 cycles.
  - Raise res_ready with req0 valid -> drain and new accept in the same cycle; next result appears the following cycle.
- Reset asserted while res_valid=1 and res_ready=0 -> res_valid=0 immediately (asynchronous), starve_cnt=0. After release, port 0 wins first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings and request bundle for the shared integer execution stage.
// Declarations only: no latency and no flow control of its own.
package alu_pkg;

    localparam int ALU_XLEN  = 32;
    localparam int ALU_TAG_W = 5;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SCOMP = 4'b1000;
    localparam logic [3:0] ALU_LUI   = 4'b1001;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRL   = 4'b1011;
    localparam logic [3:0] ALU_SRA   = 4'b1100;
    localparam logic [3:0] ALU_AND   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b1110;
    localparam logic [3:0] ALU_XOR   = 4'b1111;

    localparam logic [1:0] BC_NONE = 2'b00;
    localparam logic [1:0] BC_EQ   = 2'b01;
    localparam logic [1:0] BC_LT   = 2'b10;
    localparam logic [1:0] BC_LTU  = 2'b11;

    typedef struct packed {
        logic [3:0]           ctrl;
        logic                 neg;
        logic [1:0]           bc;
        logic [ALU_XLEN-1:0]  a;
        logic [ALU_XLEN-1:0]  b;
        logic [ALU_TAG_W-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/alu_exec.sv
// Combinational integer ALU: arithmetic, shifts, logic ops and compare-to-flag.
// Zero latency, no flow control; the caller registers the result.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
)(
    input  logic [3:0]      ctrl_i,
    input  logic            neg_i,
    input  logic [1:0]      bc_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] data_o,
    output logic            flag_o
);

    logic [4:0] shamt;
    logic       cmp;

    assign shamt = b_i[4:0];

    always_comb begin
        data_o = '0;
        flag_o = 1'b0;
        cmp    = 1'b0;
        case (ctrl_i)
            ALU_ADD: data_o = a_i + b_i;
            ALU_SUB: data_o = a_i - b_i;
            ALU_LUI: data_o = b_i;
            ALU_SLL: data_o = a_i << shamt;
            ALU_SRL: data_o = a_i >> shamt;
            ALU_SRA: data_o = $unsigned($signed(a_i) >>> shamt);
            ALU_AND: data_o = a_i & b_i;
            ALU_OR:  data_o = a_i | b_i;
            ALU_XOR: data_o = a_i ^ b_i;
            ALU_SCOMP: begin
                case (bc_i)
                    BC_EQ:   cmp = (a_i == b_i);
                    BC_LT:   cmp = ($signed(a_i) < $signed(b_i));
                    BC_LTU:  cmp = (a_i < b_i);
                    default: cmp = 1'b0;
                endcase
                // neg only ever affects compares; other ops keep flag at 0
                flag_o = cmp ^ neg_i;
                data_o = {{(XLEN-1){1'b0}}, flag_o};
            end
            default: begin
                data_o = '0;
                flag_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester ALU share: port 0 priority, port 1 forced through after STARVE_LIMIT waits.
// Latency 1 cycle accept->res_valid; ready is withheld while the result register is held.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int XLEN         = ALU_XLEN,
    parameter int TAG_W        = ALU_TAG_W,
    parameter int STARVE_LIMIT = 4
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic             req0_neg,
    input  logic [1:0]       req0_bc,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic             req1_neg,
    input  logic [1:0]       req1_bc,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [TAG_W-1:0] res_tag,
    output logic [XLEN-1:0]  res_data,
    output logic             res_flag
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    alu_req_t req0_s, req1_s, sel_s;

    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [XLEN-1:0]  res_data_q, res_data_d;
    logic             res_flag_q, res_flag_d;
    logic [3:0]       starve_q, starve_d;

    logic adv, g0, g1, acc;
    logic [XLEN-1:0] exec_data;
    logic            exec_flag;

    assign req0_s = '{ctrl: req0_ctrl, neg: req0_neg, bc: req0_bc, a: req0_a, b: req0_b, tag: req0_tag};
    assign req1_s = '{ctrl: req1_ctrl, neg: req1_neg, bc: req1_bc, a: req1_a, b: req1_b, tag: req1_tag};

    // rstn gates the stage so nothing is accepted while reset is held
    assign adv = (~res_valid_q | res_ready) & rstn;
    assign g1  = req1_valid & (~req0_valid | (starve_q >= LIMIT));
    assign g0  = req0_valid & ~g1;
    assign acc = (g0 | g1) & adv;

    assign req0_ready = g0 & adv;
    assign req1_ready = g1 & adv;

    assign sel_s = g1 ? req1_s : req0_s;

    alu_exec #(.XLEN(XLEN)) u_exec (
        .ctrl_i (sel_s.ctrl),
        .neg_i  (sel_s.neg),
        .bc_i   (sel_s.bc),
        .a_i    (sel_s.a),
        .b_i    (sel_s.b),
        .data_o (exec_data),
        .flag_o (exec_flag)
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        res_flag_d  = res_flag_q;
        if (acc) begin
            res_valid_d = 1'b1;
            res_id_d    = g1;
            res_tag_d   = sel_s.tag;
            res_data_d  = exec_data;
            res_flag_d  = exec_flag;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end

        // the wait count keeps climbing during back-pressure so port 1 wins once the stage reopens
        if (!req1_valid || (g1 && adv)) begin
            starve_d = '0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
            starve_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
            res_flag_q  <= res_flag_d;
            starve_q    <= starve_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;
    assign res_flag  = res_flag_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus random traffic against a reference model.
module tb_alu_share_arb;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0_valid, req0_ready, req0_neg;
    logic [3:0]  req0_ctrl;
    logic [1:0]  req0_bc;
    logic [31:0] req0_a, req0_b;
    logic [4:0]  req0_tag;
    logic        req1_valid, req1_ready, req1_neg;
    logic [3:0]  req1_ctrl;
    logic [1:0]  req1_bc;
    logic [31:0] req1_a, req1_b;
    logic [4:0]  req1_tag;
    logic        res_valid, res_ready, res_id, res_flag;
    logic [4:0]  res_tag;
    logic [31:0] res_data;

    always #5 clk = ~clk;

    alu_share_arb #(.XLEN(32), .TAG_W(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_neg(req0_neg), .req0_bc(req0_bc), .req0_a(req0_a), .req0_b(req0_b),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_neg(req1_neg), .req1_bc(req1_bc), .req1_a(req1_a), .req1_b(req1_b),
        .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_tag(res_tag), .res_data(res_data), .res_flag(res_flag)
    );

    typedef struct {
        bit          id;
        logic [4:0]  tag;
        logic [31:0] data;
        bit          flag;
    } exp_t;

    exp_t sb_q[$];
    bit   id_log[$];
    int   checks   = 0;
    int   failures = 0;
    bit   m_rv;
    int   m_w;
    logic [4:0] tag_ctr = 5'd0;
    bit   mon_have;
    exp_t mon_snap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the operation definitions, using literal encodings
    function automatic exp_t ref_op(input bit id, input logic [3:0] c, input bit n,
                                    input logic [1:0] bc, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] t);
        exp_t e;
        int   sh;
        bit   cmp;
        e.id = id; e.tag = t; e.data = 32'd0; e.flag = 1'b0;
        sh = int'(b % 32);
        cmp = 1'b0;
        case (c)
            4'b0000: e.data = a + b;
            4'b0001: e.data = a - b;
            4'b1001: e.data = b;
            4'b1010: e.data = a << sh;
            4'b1011: e.data = a >> sh;
            4'b1100: e.data = a[31] ? ~((~a) >> sh) : (a >> sh);
            4'b1101: e.data = a & b;
            4'b1110: e.data = a | b;
            4'b1111: e.data = a ^ b;
            4'b1000: begin
                if (bc == 2'b01)      cmp = (a == b);
                else if (bc == 2'b10) cmp = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
                else if (bc == 2'b11) cmp = (a < b);
                e.flag = cmp ^ n;
                e.data = {31'd0, e.flag};
            end
            default: begin e.data = 32'd0; e.flag = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic set_req(input int p, input bit v, input logic [3:0] c, input bit n,
                           input logic [1:0] bc, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] t);
        if (p == 0) begin
            req0_valid = v; req0_ctrl = c; req0_neg = n; req0_bc = bc;
            req0_a = a; req0_b = b; req0_tag = t;
        end else begin
            req1_valid = v; req1_ctrl = c; req1_neg = n; req1_bc = bc;
            req1_a = a; req1_b = b; req1_tag = t;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_req(input int p, input bit v);
        set_req(p, v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), rand_operand(), rand_operand(), tag_ctr);
        tag_ctr = tag_ctr + 5'd1;
    endtask

    // One cycle: check grant/ready against the arbitration rules, record accepts, advance the model
    task automatic step();
        bit adv, g0, g1;
        @(negedge clk); #1;
        adv = !m_rv || res_ready;
        g1  = req1_valid && (!req0_valid || m_w >= LIMIT);
        g0  = req0_valid && !g1;
        chk("res_valid_model", res_valid, m_rv);
        chk("req0_ready", req0_ready, g0 && adv);
        chk("req1_ready", req1_ready, g1 && adv);
        if (g0 && adv)
            sb_q.push_back(ref_op(1'b0, req0_ctrl, req0_neg, req0_bc, req0_a, req0_b, req0_tag));
        else if (g1 && adv)
            sb_q.push_back(ref_op(1'b1, req1_ctrl, req1_neg, req1_bc, req1_a, req1_b, req1_tag));
        if (!req1_valid || (g1 && adv)) m_w = 0;
        else if (m_w < LIMIT)            m_w = m_w + 1;
        m_rv = ((g0 || g1) && adv) ? 1'b1 : (res_ready ? 1'b0 : m_rv);
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every completed result handshake, checks held results stay stable
    initial begin
        exp_t e;
        mon_have = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mon_have = 1'b0;
            end else begin
                if (mon_have && res_valid) begin
                    chk("hold_id",   res_id,   mon_snap.id);
                    chk("hold_tag",  res_tag,  mon_snap.tag);
                    chk("hold_data", res_data, mon_snap.data);
                    chk("hold_flag", res_flag, mon_snap.flag);
                end
                if (res_valid && res_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_id",   res_id,   e.id);
                        chk("sb_tag",  res_tag,  e.tag);
                        chk("sb_data", res_data, e.data);
                        chk("sb_flag", res_flag, e.flag);
                        id_log.push_back(res_id);
                    end
                end
                mon_have      = res_valid && !res_ready;
                mon_snap.id   = res_id;
                mon_snap.tag  = res_tag;
                mon_snap.data = res_data;
                mon_snap.flag = res_flag;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout no_finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [4:0] bp_tag;
        rstn = 1'b0;
        res_ready = 1'b1;
        set_req(0, 1'b1, 4'b0000, 1'b0, 2'b00, 32'd1, 32'd2, 5'd1);
        set_req(1, 1'b1, 4'b0000, 1'b0, 2'b00, 32'd3, 32'd4, 5'd2);
        m_rv = 1'b0; m_w = 0;
        #22;
        chk("rst_res_valid", res_valid, 32'd0);
        chk("rst_res_id",    res_id,    32'd0);
        chk("rst_res_tag",   res_tag,   32'd0);
        chk("rst_res_data",  res_data,  32'd0);
        chk("rst_res_flag",  res_flag,  32'd0);
        chk("rst_req0_ready", req0_ready, 32'd0);
        chk("rst_req1_ready", req1_ready, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Port 0 alone: SUB 5-7
        set_req(0, 1'b1, 4'b0001, 1'b0, 2'b01, 32'd5, 32'd7, 5'd3);
        req1_valid = 1'b0;
        step();
        chk("sub_valid", res_valid, 32'd1);
        chk("sub_id",    res_id,    32'd0);
        chk("sub_data",  res_data,  32'hFFFF_FFFE);
        chk("sub_flag",  res_flag,  32'd0);
        chk("sub_tag",   res_tag,   32'd3);

        // Port 1 alone: negated signed compare, then arithmetic shift
        req0_valid = 1'b0;
        set_req(1, 1'b1, 4'b1000, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'd1, 5'd9);
        step();
        chk("scomp_id",   res_id,   32'd1);
        chk("scomp_flag", res_flag, 32'd0);
        chk("scomp_data", res_data, 32'd0);
        chk("scomp_tag",  res_tag,  32'd9);
        set_req(1, 1'b1, 4'b1100, 1'b0, 2'b00, 32'h8000_0000, 32'd31, 5'd10);
        step();
        chk("sra_data", res_data, 32'hFFFF_FFFF);
        req1_valid = 1'b0;
        step();

        // Both ports continuously valid: fairness pattern
        id_log.delete();
        for (int i = 0; i < 10; i++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("fair_count", id_log.size(), 32'd10);
        for (int i = 0; i < 10 && i < id_log.size(); i++)
            chk($sformatf("fair_id_%0d", i), id_log[i], (i % 5 == 4) ? 32'd1 : 32'd0);

        // Back-pressure: held result blocks both ports
        res_ready = 1'b0;
        rand_req(0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            step();
        end
        chk("bp_req0_ready", req0_ready, 32'd0);
        chk("bp_req1_ready", req1_ready, 32'd0);
        req1_valid = 1'b0;
        res_ready = 1'b1;
        rand_req(0, 1'b1);
        bp_tag = req0_tag;
        step();
        chk("bp_refill_valid", res_valid, 32'd1);
        chk("bp_refill_tag",   res_tag,   bp_tag);

        // Reset while a result is held and port 1 has starved
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            step();
        end
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_res_valid", res_valid, 32'd0);
        chk("arst_res_data",  res_data,  32'd0);
        chk("arst_res_tag",   res_tag,   32'd0);
        chk("arst_res_id",    res_id,    32'd0);
        sb_q.delete();
        m_rv = 1'b0; m_w = 0;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        res_ready = 1'b1;
        step();
        chk("post_rst_first_id", res_id, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            rand_req(0, 1'($urandom_range(0, 1)));
            rand_req(1, 1'($urandom_range(0, 1)));
            step();
        end

        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
